// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard controller bundle between the pipeline and hazard_ctrl
//   pipeline -> ctrl : start_i, ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
//                      branch_taken_i, jump_i, mem_stall_i
//   ctrl -> pipeline : pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
//                      pipe_stall_o, pc_sel_o, state_o, stall_cnt_o, hazard_cnt_o
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [4:0]       ifid_rs_i;
  logic [4:0]       ifid_rt_i;
  logic             idex_memread_i;
  logic [4:0]       idex_rt_i;
  logic             branch_taken_i;
  logic             jump_i;
  logic             mem_stall_i;
  logic             pc_stall_o;
  logic             ifid_stall_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             pipe_stall_o;
  logic [1:0]       pc_sel_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] hazard_cnt_o;

  modport master (
    output start_i, ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, jump_i, mem_stall_i,
    input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
           pipe_stall_o, pc_sel_o, state_o, stall_cnt_o, hazard_cnt_o
  );

  modport slave (
    input  start_i, ifid_rs_i, ifid_rt_i, idex_memread_i, idex_rt_i,
           branch_taken_i, jump_i, mem_stall_i,
    output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
           pipe_stall_o, pc_sel_o, state_o, stall_cnt_o, hazard_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard and PC sequencing controller
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : hazard_ctrl_if.slave (hazard inputs, stall/flush/bubble/pc_sel outputs,
//           state and saturating performance counters)
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10,
    UNUSED   = 2'b11
  } state_t;

  localparam logic [1:0] SEL_PC4 = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;

  state_t           state_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] hazard_cnt_q;

  logic       active;
  logic       load_use;
  logic       hazard_hit;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       pipe_stall;
  logic [1:0] pc_sel;

  // MEM_WAIT with memory ready behaves exactly like RUN, so both are "active".
  assign active = (state_q == RUN) || (state_q == MEM_WAIT);

  // A load to r0 never creates a dependency.
  assign load_use = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                    ((bus.idex_rt_i == bus.ifid_rs_i) || (bus.idex_rt_i == bus.ifid_rt_i));

  assign hazard_hit = active && !bus.mem_stall_i && load_use;

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_stall  = 1'b0;
    pc_sel      = SEL_PC4;
    if (!active || bus.mem_stall_i) begin
      // Idle or memory freeze: everything holds, no flush/bubble.
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      pipe_stall = 1'b1;
    end else if (load_use) begin
      // Branch/jump is deliberately ignored here; ID is held so it is
      // re-evaluated next cycle once the load has moved on.
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end else if (bus.jump_i) begin
      pc_sel     = SEL_JMP;
      ifid_flush = 1'b1;
    end else if (bus.branch_taken_i) begin
      pc_sel     = SEL_BR;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:     if (bus.start_i) state_q <= RUN;
        RUN: begin
          if (bus.mem_stall_i)   state_q <= MEM_WAIT;
          else if (!bus.start_i) state_q <= IDLE;
        end
        // start_i is only looked at once memory is no longer busy.
        MEM_WAIT: if (!bus.mem_stall_i) state_q <= bus.start_i ? RUN : IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q  <= '0;
      hazard_cnt_q <= '0;
    end else begin
      if (active && pc_stall && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (hazard_hit && (hazard_cnt_q != {CNT_W{1'b1}}))
        hazard_cnt_q <= hazard_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_stall_o    = pc_stall;
  assign bus.ifid_stall_o  = ifid_stall;
  assign bus.ifid_flush_o  = ifid_flush;
  assign bus.idex_bubble_o = idex_bubble;
  assign bus.pipe_stall_o  = pipe_stall;
  assign bus.pc_sel_o      = pc_sel;
  assign bus.state_o       = state_q;
  assign bus.stall_cnt_o   = stall_cnt_q;
  assign bus.hazard_cnt_o  = hazard_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and PC sequencing controller for the 5-stage CPU. It decides each cycle whether the PC and the IF/ID register advance, hold or flush. It also decides whether ID/EX receives a bubble, whether the whole pipeline freezes for a busy memory, and which next-PC source is selected. `pc_stall_o` drives the PC register's `select_i`; the same `start_i` feeds both blocks.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating performance counters.

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `start_i`, in, 1: global run enable.
- `ifid_rs_i`, in, 5: rs field of the instruction in ID.
- `ifid_rt_i`, in, 5: rt field of the instruction in ID.
- `idex_memread_i`, in, 1: the instruction in EX is a load.
- `idex_rt_i`, in, 5: destination register of the load in EX.
- `branch_taken_i`, in, 1: branch resolved taken in ID.
- `jump_i`, in, 1: jump decoded in ID.
- `mem_stall_i`, in, 1: instruction or data memory busy.
- `pc_stall_o`, out, 1: 1 = hold the PC (to PC `select_i`).
- `ifid_stall_o`, out, 1: hold the IF/ID register.
- `ifid_flush_o`, out, 1: zero the IF/ID register (NOP).
- `idex_bubble_o`, out, 1: zero the ID/EX control fields.
- `pipe_stall_o`, out, 1: freeze ID/EX, EX/MEM and MEM/WB.
- `pc_sel_o`, out, 2: next-PC source; 00 = PC+4, 01 = branch target, 10 = jump target.
- `state_o`, out, 2: current FSM state.
- `stall_cnt_o`, out, CNT_W: count of stalled cycles.
- `hazard_cnt_o`, out, CNT_W: count of load-use events.

## Operation
States:
- IDLE = 00: entered on reset.
- RUN = 01.
- MEM_WAIT = 10.
- 11 is unused and recovers to IDLE.

Transitions:
- IDLE goes to RUN when `start_i` = 1.
- RUN goes to MEM_WAIT when `mem_stall_i` = 1. Otherwise RUN goes to IDLE when `start_i` = 0.
- MEM_WAIT goes to RUN when `mem_stall_i` = 0 and `start_i` = 1. It goes to IDLE when `mem_stall_i` = 0 and `start_i` = 0. A `start_i` drop is never honoured mid memory access.

Outputs are combinational from the state and current inputs (Mealy). Unless listed, an output is 0 and `pc_sel_o` is 00. Conditions below are in priority order:
1. In IDLE: `pc_stall_o`, `ifid_stall_o` and `pipe_stall_o` are 1.
2. In RUN or MEM_WAIT with `mem_stall_i` = 1 (memory freeze): `pc_stall_o`, `ifid_stall_o` and `pipe_stall_o` are 1. No flush or bubble is issued.
3. Load-use hazard, defined as `idex_memread_i` = 1, `idex_rt_i` != 0, and `idex_rt_i` equal to `ifid_rs_i` or `ifid_rt_i`:
   - `pc_stall_o`, `ifid_stall_o` and `idex_bubble_o` are 1.
   - A simultaneous branch or jump is ignored this cycle; it is re-evaluated next cycle, when the ID instruction is unchanged.
4. `jump_i` = 1: `pc_sel_o` = 10 and `ifid_flush_o` = 1.
5. `branch_taken_i` = 1: `pc_sel_o` = 01 and `ifid_flush_o` = 1.
6. Otherwise all pass-through: `pc_sel_o` = 00 and no stall.

In MEM_WAIT with `mem_stall_i` = 0, outputs are evaluated as in RUN (rules 3–6), so the pipeline advances in that cycle.

Counters:
- `stall_cnt_o` increments on every edge where the state is not IDLE and `pc_stall_o` = 1.
- `hazard_cnt_o` increments on every edge where rule 3 is active.
- Both saturate at all-ones and never wrap.
- Both clear only on reset.

## Timing
- Reset (asynchronous, immediate): state IDLE, counters 0. Outputs then show IDLE values: `pc_stall_o` = 1, `ifid_stall_o` = 1, `pipe_stall_o` = 1, all others 0, `pc_sel_o` = 00, `state_o` = 00.
- Reset asserted in any state, including MEM_WAIT, aborts to IDLE without waiting for memory.
- Combinational outputs respond in the same cycle as their inputs, so the PC register samples the decision on the following edge.
- `start_i` rising in IDLE: outputs stay at IDLE values during that cycle, and the first PC advance happens on the edge after the transition to RUN. `start_i` low in RUN yields IDLE outputs from the next cycle.
- A load-use hazard costs exactly 1 stall cycle: the bubble moves the load to MEM, so the comparison clears.
- A taken branch or jump costs 1 flushed slot and no stall.
- A memory stall of N cycles gives N freeze cycles. `pc_stall_o` = 1 for exactly N cycles; the state is MEM_WAIT from the 2nd to the N-th cycle.

## Test plan
- **Reset/start:** hold `rst_i` = 0, then release with `start_i` = 0 → `state_o` = 00 and `pc_stall_o` = 1 indefinitely; `stall_cnt_o` stays 0. Raise `start_i` → `state_o` = 01 next edge and `pc_stall_o` = 0.
- **Load-use:** `idex_memread_i` = 1, `idex_rt_i` = 8, `ifid_rs_i` = 8 for one cycle → `pc_stall_o`, `ifid_stall_o` and `idex_bubble_o` are 1 for that cycle; `hazard_cnt_o` becomes 1. Repeat with `idex_rt_i` = 0 → no stall.
- **Branch/jump:** `branch_taken_i` = 1 → `pc_sel_o` = 01 and `ifid_flush_o` = 1. `jump_i` and `branch_taken_i` both 1 → `pc_sel_o` = 10. Load-use together with `branch_taken_i` → stall, `pc_sel_o` = 00.
- **Memory stall:** `mem_stall_i` = 1 for 3 cycles → `pipe_stall_o` = 1 for exactly 3 cycles; `state_o` is 10 for cycles 2–3; `stall_cnt_o` rises by 3. Drop `start_i` mid-stall → state goes to IDLE only after `mem_stall_i` = 0.
- **Saturation:** with `CNT_W` = 4, hold `mem_stall_i` = 1 for 20 cycles → `stall_cnt_o` = 15 and stays at 15.
- **Mid-operation reset:** assert `rst_i` = 0 asynchronously in MEM_WAIT → `state_o` = 00 and counters = 0 immediately, without waiting for a clock edge.
